// File: rtl/fetch_controller_pkg.sv
// Shared constants for the instruction-fetch front end.
// Mirrors the legacy Constants.v values.
package fetch_controller_pkg;

  localparam int INSTRUCTION_LEN = 32;
  localparam int INSTRUCTION_MEM_SIZE = 1024;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam int FETCH_DEPTH = 2;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-to-decode valid/ready handshake bundle.
// master = fetch side, slave = decode side.
interface fetch_controller_if #(
  parameter int W = 32
);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_inst;
  logic [W-1:0] out_pc;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO for fetched entries.
// clr beats push/pop; push into a full FIFO is legal only with pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; visibility is governed by count.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, buffers
// {inst, pc+4} and hands it to decode; handles redirect and OOB.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int INST_LEN = INSTRUCTION_LEN,
  parameter logic [INST_LEN-1:0] RESET_PC =
    INST_LEN'(fetch_controller_pkg::RESET_PC),
  parameter int MEM_BYTES  = INSTRUCTION_MEM_SIZE,
  parameter int FIFO_DEPTH = FETCH_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  output logic [INST_LEN-1:0] imem_addr,
  input  logic [INST_LEN-1:0] imem_data,
  input  logic                branch_taken,
  input  logic [INST_LEN-1:0] branch_addr,
  fetch_controller_if.master  dec,
  output logic                fetch_oob
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [INST_LEN-1:0] LAST_PC =
    INST_LEN'(MEM_BYTES - 4);

  logic [INST_LEN-1:0]   pc_q, pc_d, pc_inc;
  logic [2*INST_LEN-1:0] head;
  logic [CW-1:0]         count;
  logic                  oob, pop, push;
  logic                  empty, full;
  logic                  unused_bits;

  assign oob    = (pc_q > LAST_PC);
  assign pop    = dec.out_valid & dec.out_ready;
  assign push   = !branch_taken & !oob & (!full | pop);
  assign pc_inc = pc_q + INST_LEN'(4);

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      branch_taken: pc_d = {branch_addr[INST_LEN-1:2], 2'b00};
      push:         pc_d = pc_inc;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // A redirect flushes everything buffered, including a pending pop.
  fetch_fifo #(
    .W     (2 * INST_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (branch_taken),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_data, pc_inc}),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign imem_addr     = pc_q;
  assign fetch_oob     = oob;
  assign dec.out_valid = !empty;
  assign dec.out_inst  =
    head[2*INST_LEN-1:INST_LEN] & {INST_LEN{!empty}};
  assign dec.out_pc    =
    head[INST_LEN-1:0] & {INST_LEN{!empty}};

  assign unused_bits = ^{count, branch_addr[1:0]};

endmodule

// File: tb/tb_fetch_controller.sv
// Random + directed bench for fetch_controller (two sizes)
// against a queue-based fetch model.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, br, rdy;
  logic [31:0] ba;
  logic [31:0] mem [256];

  logic [31:0] addr [2];
  logic [31:0] idata [2];
  logic        oob [2];
  logic        vld [2];
  logic [31:0] oinst [2];
  logic [31:0] opc [2];

  fetch_controller_if #(.W(32)) bus0 ();
  fetch_controller_if #(.W(32)) bus1 ();

  assign bus0.out_ready = rdy;
  assign bus1.out_ready = rdy;
  assign idata[0] = mem[addr[0][9:2]];
  assign idata[1] = mem[addr[1][9:2]];
  assign vld[0]   = bus0.out_valid;
  assign vld[1]   = bus1.out_valid;
  assign oinst[0] = bus0.out_inst;
  assign oinst[1] = bus1.out_inst;
  assign opc[0]   = bus0.out_pc;
  assign opc[1]   = bus1.out_pc;

  fetch_controller #(.MEM_BYTES(1024)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (addr[0]),
    .imem_data    (idata[0]),
    .branch_taken (br),
    .branch_addr  (ba),
    .dec          (bus0),
    .fetch_oob    (oob[0])
  );

  fetch_controller #(.MEM_BYTES(16)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (addr[1]),
    .imem_data    (idata[1]),
    .branch_taken (br),
    .branch_addr  (ba),
    .dec          (bus1),
    .fetch_oob    (oob[1])
  );

  logic [63:0] mq [2][$];
  logic [31:0] mpc [2];
  int          mb [2];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: one fetch per free slot, flushed by redirect.
  task automatic model_step();
    logic [63:0] dropped;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mpc[k] = RESET_PC;
      end else if (br) begin
        mq[k].delete();
        mpc[k] = {ba[31:2], 2'b00};
      end else begin
        if (rdy && mq[k].size() > 0) dropped = mq[k].pop_front();
        if (mpc[k] <= 32'(mb[k] - 4) && mq[k].size() < 2) begin
          mq[k].push_back({mem[mpc[k][9:2]], mpc[k] + 32'd4});
          mpc[k] = mpc[k] + 32'd4;
        end
      end
    end
  endtask

  task automatic check_all();
    logic        ev;
    logic [63:0] hd;
    for (int k = 0; k < 2; k++) begin
      ev = (mq[k].size() > 0);
      hd = ev ? mq[k][0] : 64'd0;
      check($sformatf("valid%0d", k), 32'(vld[k]), 32'(ev));
      check($sformatf("inst%0d", k), oinst[k], hd[63:32]);
      check($sformatf("pc%0d", k), opc[k], hd[31:0]);
      check($sformatf("addr%0d", k), addr[k], mpc[k]);
      check($sformatf("oob%0d", k), 32'(oob[k]),
            32'(mpc[k] > 32'(mb[k] - 4)));
    end
  endtask

  task automatic cyc(input logic r, input logic b,
                     input logic [31:0] a, input logic rd);
    rst = r;
    br  = b;
    ba  = a;
    rdy = rd;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [31:0] prev;

  initial begin
    mb[0] = 1024;
    mb[1] = 16;
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'hE3A0_0014;
    mem[1] = 32'hE3A0_1A01;
    rst = 1'b1; br = 1'b0; ba = '0; rdy = 1'b0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_valid", 32'(vld[0]), 32'd0);
    check("rst_oob", 32'(oob[0]), 32'd0);
    check("rst_inst", oinst[0], 32'd0);

    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 1);
      check("t1_addr", addr[0], 32'(4 * i));
      if (i == 1) begin
        check("t1_inst0", oinst[0], 32'hE3A0_0014);
        check("t1_pc0", opc[0], 32'd4);
      end
      if (i == 2) begin
        check("t1_inst1", oinst[0], 32'hE3A0_1A01);
        check("t1_pc1", opc[0], 32'd8);
      end
    end

    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    check("t2_hold", addr[0], 32'd8);
    check("t2_head", opc[0], 32'd4);
    for (int i = 0; i < 3; i++) begin
      prev = addr[0];
      cyc(0, 0, 0, 1);
      check("t4_step", addr[0], prev + 32'd4);
      check("t4_valid", 32'(vld[0]), 32'd1);
    end
    repeat (3) cyc(0, 0, 0, 1);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h3D, 0);
    check("t3_bubble", 32'(vld[0]), 32'd0);
    check("t3_addr", addr[0], 32'h3C);
    cyc(0, 0, 0, 0);
    check("t3_inst", oinst[0], mem[15]);
    check("t3_pc", opc[0], 32'h40);

    cyc(1, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 1);
    check("t5_oob", 32'(oob[1]), 32'd1);
    check("t5_drained", 32'(vld[1]), 32'd0);
    check("t5_hold", addr[1], 32'd16);
    cyc(0, 1, 32'h4, 1);
    check("t5_clear", 32'(oob[1]), 32'd0);
    cyc(0, 0, 0, 1);
    check("t5_inst", oinst[1], mem[1]);
    check("t5_pc", opc[1], 32'd8);

    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h80, 0);
    check("t6_addr", addr[0], 32'd0);
    check("t6_valid", 32'(vld[0]), 32'd0);
    check("t6_oob", 32'(oob[0]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(63) == 0, $urandom_range(7) == 0,
          32'($urandom_range(1100)), $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer for the ARM core.
- Owns the program counter and drives the byte address of the combinational-read instruction memory.
- Buffers fetched words in a small FIFO and hands {instruction, PC+4} to decode over a valid/ready handshake.
- Handles branch redirect/flush and out-of-range fetch detection.

Parameters:
- INST_LEN, 32, instruction and address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- MEM_BYTES, 1024, size of instruction memory in bytes; the last legal fetch address is MEM_BYTES-4.
- FIFO_DEPTH, 2, number of buffered fetch entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  INST_LEN  byte address to instruction memory (equals the pc register).
- imem_data  in  INST_LEN  instruction word, combinationally valid in the same cycle as imem_addr.
- branch_taken  in  1  redirect request from execute.
- branch_addr  in  INST_LEN  redirect target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  INST_LEN  head instruction.
- out_pc  out  INST_LEN  head instruction address + 4.
- fetch_oob  out  1  the PC is past the last legal fetch address, so fetching is halted.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pc←RESET_PC; FIFO count←0; read/write pointers←0.
  - Outputs: out_valid=0, fetch_oob=0. out_inst and out_pc are 0 when empty (head data is masked with out_valid).
- Derived signals:
  - pop = out_valid & out_ready.
  - oob = (pc > MEM_BYTES-4).
  - push = !branch_taken & !oob & ((count < FIFO_DEPTH) | pop).
- On push:
  - FIFO[wptr] ← {imem_data, pc+4}.
  - pc ← pc+4.
  - wptr advances modulo FIFO_DEPTH.
- On pop:
  - rptr advances modulo FIFO_DEPTH.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged. A push into a full FIFO while popping is legal.
- branch_taken has the highest priority and overrides push and pop in that cycle:
  - pc ← {branch_addr[INST_LEN-1:2], 2'b00}.
  - count ← 0; pointers ← 0.
  - No push that cycle.
  - The next cycle fetches from the target.
- Redirect-to-output latency:
  - Cycle after branch_taken: out_valid=0.
  - Following cycle: target instruction at the head.
  - The branch bubble is therefore exactly 1 cycle.
- Reset latency: the first posedge with rst=0 pushes the instruction at RESET_PC; out_valid=1 after that edge.
- Full FIFO with out_ready=0: pc holds; imem_addr stays stable; the head and all entries are unchanged.
- Out of range:
  - fetch_oob = oob, registered through pc (combinational from the pc register).
  - While oob holds: no pushes, pc holds. Already-buffered entries still drain normally.
  - Only branch_taken to a legal address or rst clears it.
- Wrap-around: pc+4 is computed in INST_LEN bits; overflow past 2^32 is irrelevant because oob triggers first.
- branch_taken together with rst: rst wins.
- Throughput: with out_ready held at 1, one instruction per cycle.

Decomposition:
- Shared constants go in Constants.v: INSTRUCTION_LEN, INSTRUCTION_MEM_SIZE (feeds MEM_BYTES), RESET_PC, NOP encoding.
- One sub-module, fetch_fifo: parameterised depth/width synchronous FIFO.
  - Inputs: clk, rst, clr, push, pop, wdata.
  - Outputs: rdata, count, empty, full.
  - clr takes priority over push/pop.
- PC logic, oob compare and push/branch arbitration stay in fetch_controller.

Test Plan:
1. Reset then out_ready=1 for 3 cycles, with memory preloaded at 0 and 4 (0x0 = 0xE3A00014, 0x4 = 0xE3A01A01):
   - The first accepted entry is out_inst=0xE3A00014, out_pc=4.
   - The second is 0xE3A01A01, out_pc=8.
   - imem_addr steps 0,4,8,12.
2. Backpressure: out_ready=0 for 5 cycles after reset, then 1:
   - count saturates at 2; imem_addr holds at 8 while full.
   - On release, 1 instruction is accepted per cycle in program order with no loss or duplication.
3. Branch: with 2 entries buffered, pulse branch_taken with branch_addr=0x3D (→0x3C):
   - Next cycle out_valid=0 and imem_addr=0x3C.
   - The following cycle the head is the word at 0x3C, with out_pc=0x40.
4. Simultaneous push/pop when full: out_ready=1 while count=2 → count stays 2 and pc advances by 4 each cycle.
5. Out of range: run with MEM_BYTES=16 and out_ready=1:
   - The fetches at 0,4,8,12 are delivered.
   - pc=16 → fetch_oob=1, no further pushes, out_valid falls once drained.
   - Then branch to 0x4 → fetch_oob=0 and the word at 0x4 is delivered.
6. Reset mid-stream: assert rst with the FIFO full and branch_taken=1 in the same cycle → pc=RESET_PC, out_valid=0, fetch_oob=0, and the branch is ignored.
